// File: rtl/median_window_serializer.sv
// Median stage feeder: buffers two image lines, builds the 3x3 neighbourhood
// of each interior pixel and streams it as a 9-word burst, then waits for DSO.
module median_window_serializer #(
   parameter int TAILLE = 8,
   parameter int WIDTH  = 16
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [TAILLE-1:0] PIX_IN,
   input  logic              PIX_VALID,
   input  logic              PIX_SOF,
   output logic              PIX_READY,
   output logic              DSI,
   output logic [TAILLE-1:0] DO,
   input  logic              DSO
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_COL = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_ACCEPT,
      ST_SEND,
      ST_WAIT
   } state_t;

   state_t state;
   state_t state_next;

   logic [CW-1:0] col;
   logic [CW-1:0] pos_col;
   logic [CW-1:0] col_next;
   logic [1:0]    row;
   logic [1:0]    pos_row;
   logic [1:0]    row_next;
   logic [3:0]    k;
   logic          accept;
   logic          complete;

   logic [TAILLE-1:0] linebuf1 [WIDTH];
   logic [TAILLE-1:0] linebuf2 [WIDTH];

   // Window words 0..8: top row left-to-right, middle row, bottom row.
   logic [TAILLE-1:0] win      [9];
   logic [TAILLE-1:0] win_next [9];

   assign PIX_READY = (state == ST_ACCEPT);
   assign DSI       = (state == ST_SEND);
   assign accept    = PIX_VALID && PIX_READY;

   // Position of the pixel being presented; SOF forces it to the frame origin.
   always_comb begin
      pos_col  = PIX_SOF ? '0 : col;
      pos_row  = PIX_SOF ? '0 : row;
      complete = (pos_col >= CW'(2)) && (pos_row == 2'd2);
      col_next = pos_col + CW'(1);
      row_next = pos_row;
      if (pos_col == LAST_COL) begin
         col_next = '0;
         if (pos_row != 2'd2) begin
            row_next = pos_row + 2'd1;
         end
      end
   end

   always_comb begin
      for (int r = 0; r < 3; r++) begin
         win_next[r*3]     = win[r*3+1];
         win_next[r*3 + 1] = win[r*3+2];
         win_next[r*3 + 2] = win[r*3+2];
      end
      win_next[2] = linebuf2[pos_col];
      win_next[5] = linebuf1[pos_col];
      win_next[8] = PIX_IN;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_ACCEPT: begin
            if (accept && complete) begin
               state_next = ST_SEND;
            end
         end
         ST_SEND: begin
            if (k == 4'd8) begin
               state_next = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (DSO) begin
               state_next = ST_ACCEPT;
            end
         end
         default: state_next = ST_ACCEPT;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= ST_ACCEPT;
      end else begin
         state <= state_next;
      end
   end

   // The first burst word is loaded on the accepting edge so DSI and DO rise together.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         col <= '0;
         row <= '0;
         k   <= '0;
         DO  <= '0;
      end else begin
         if (accept) begin
            col <= col_next;
            row <= row_next;
         end
         if (accept && complete) begin
            DO <= win_next[0];
            k  <= '0;
         end else if (state == ST_SEND) begin
            if (k == 4'd8) begin
               k <= '0;
            end else begin
               k  <= k + 4'd1;
               DO <= win[k + 4'd1];
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (accept) begin
         linebuf2[pos_col] <= linebuf1[pos_col];
         linebuf1[pos_col] <= PIX_IN;
         for (int i = 0; i < 9; i++) begin
            win[i] <= win_next[i];
         end
      end
   end

endmodule
